seg7_display_arbiter: RTL and testbench
=======================================

Name: seg7_display_arbiter

Overview:
Shares the single seven-segment digit between NUM_REQ requesters (seconds counter, factorizer result, status codes).
Each requester raises a level request with a 4-bit digit. The arbiter grants round-robin and shows the latched digit for HOLD_COUNT cycles. It then blanks for GAP_COUNT cycles, so repeated identical digits stay distinguishable.
Output digit/blank feed the seg7decoder that drives uo_out[6:0].

Parameters:
NUM_REQ, 4, number of requesters; 2..8.
HOLD_COUNT, 10_000_000, cycles a granted digit is displayed (1 s at 10 MHz); 1..2^24.
GAP_COUNT, 1_000_000, blank cycles after each digit; 2..2^24.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
req  in  NUM_REQ  level request per requester; held until its done pulse.
req_digit  in  4*NUM_REQ  digit of requester i at bits [4i+3:4i]; sampled only at grant.
grant  out  NUM_REQ  one-hot, high for the whole SHOW phase of the served requester.
done  out  NUM_REQ  one-cycle pulse to the served requester when its SHOW phase ends.
digit  out  4  latched digit to seg7decoder; codes >9 pass through unmodified.
blank  out  1  1 = decoder output forced off.
busy  out  1  1 in SHOW or GAP.

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, grant=0, done=0, digit=0, blank=1, busy=0.
  - RR pointer last=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-SHOW or mid-GAP aborts immediately; no done pulse is issued.
- All outputs are registered. One 24-bit down/up phase counter serves both SHOW and GAP.
- IDLE:
  - On an edge where req!=0, pick the winner w by round-robin, searching from last+1 modulo NUM_REQ.
  - Next cycle: state=SHOW, grant[w]=1, digit=req_digit[w], blank=0, busy=1, last=w, counter cleared.
  - If req=0, stay in IDLE.
- SHOW:
  - Lasts exactly HOLD_COUNT cycles; grant is high for exactly HOLD_COUNT cycles.
  - A req drop or req_digit change during SHOW is ignored; the digit stays latched and the phase completes.
  - Then: state=GAP, grant=0, done[w]=1 for one cycle (first GAP cycle), blank=1, digit holds.
- GAP:
  - Lasts exactly GAP_COUNT cycles.
  - On the last GAP cycle, arbitrate as in IDLE using the current req.
  - If a winner exists, go directly to SHOW (no IDLE cycle); otherwise go to IDLE with busy=0.
  - GAP_COUNT>=2 guarantees a requester that drops req on the cycle after done is not re-granted.
  - A requester still holding req at the last GAP cycle is treated as a new request and served in rotation order.
- Simultaneous requests: the lowest index at or after last+1 wins. No starvation: each active requester is served within NUM_REQ slots.
- Exactly zero or one grant bit and zero or one done bit are high at any time.
- X on req_digit of non-winners must not propagate.

Optional Feature:
Macro SEG7_ARB_PRIO0_EN.
- Defined: requester 0 has fixed top priority at every arbitration point; the others stay round-robin among themselves, with last updated only for them. Preemption never occurs mid-SHOW.
- Undefined: pure round-robin across all requesters.

Decomposition:
- Package seg7_arb_pkg holds:
  - state enum {IDLE, SHOW, GAP}
  - CNT_W=24
  - DIGIT_W=4
  - BLANK_CODE constant
- Sub-module rr_pick: combinational round-robin picker with inputs req and last, outputs the one-hot winner and its index. The ifdef for SEG7_ARB_PRIO0_EN lives inside rr_pick.
- The FSM and counter stay in the top module.

Test Plan:
All scenarios use HOLD_COUNT=4, GAP_COUNT=2, NUM_REQ=4.
1. Reset, then req=0001, digit0=7 -> next cycle grant=0001, digit=7, blank=0 for 4 cycles; done=0001 one cycle; blank=1 for 2 cycles; idle busy=0 once req drops.
2. req=1111 held continuously, digits 1,2,3,4 -> grants 0,1,2,3,0 in order; each SHOW lasts 4 cycles, each GAP 2 cycles; no idle cycle between slots.
3. req_digit[0] changed from 5 to 9 and req[0] dropped mid-SHOW -> digit stays 5 for all 4 cycles; done still pulses.
4. reset asserted on SHOW cycle 2 -> next cycle grant=0, done=0, blank=1, state IDLE; after release, requester 0 is served first.
5. Requester 2 re-requests immediately after its done while req1 is active -> requester 1 is served before requester 2 again.
6. With SEG7_ARB_PRIO0_EN defined, req=1110 then req[0] rises during a SHOW of requester 1 -> requester 0 wins the next slot ahead of 2 and 3; without the macro, requester 2 wins.

Source files
------------

// File: rtl/seg7_arb_pkg.sv
// seg7_arb_pkg: shared types and constants for the seven-segment display arbiter
package seg7_arb_pkg;
  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
  localparam int CNT_W = 24;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'h0;
endpackage

// File: rtl/seg7_display_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker searching from last+1 modulo N
// Ports: req (request vector), last (previous winner index), gnt (one-hot winner),
//        idx (winner index), any (a winner exists), upd (winner may advance last).
// Macro SEG7_ARB_PRIO0_EN: requester 0 wins outright and never moves last;
//        the others stay round-robin among themselves.
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          upd
);
`ifdef SEG7_ARB_PRIO0_EN
  localparam logic [N-1:0] RR_MASK = {{(N-1){1'b1}}, 1'b0};
`else
  localparam logic [N-1:0] RR_MASK = '1;
`endif
  logic [N-1:0] rr_req;
  logic [IW-1:0] pos;
  logic rr_any;
  assign rr_req = req & RR_MASK;
  always_comb begin
    idx = '0;
    pos = '0;
    rr_any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      pos = IW'((int'(last) + k) % N);
      if (!rr_any && rr_req[pos]) begin
        rr_any = 1'b1;
        idx = pos;
      end
    end
`ifdef SEG7_ARB_PRIO0_EN
    if (req[0]) idx = '0;
    any = rr_any || req[0];
    upd = rr_any && !req[0];
`else
    any = rr_any;
    upd = rr_any;
`endif
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/seg7_display_arbiter.sv
// seg7_display_arbiter: shares one seven-segment digit between requesters, round-robin
// Ports: clk, reset (sync, active-high); req/req_digit from requesters;
//        grant (one-hot during SHOW), done (pulse on first GAP cycle);
//        digit/blank to the seg7 decoder; busy high in SHOW or GAP.
// Macro SEG7_ARB_PRIO0_EN (in rr_pick): requester 0 gets fixed top priority.
module seg7_display_arbiter
  import seg7_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int HOLD_COUNT = 10_000_000,
  parameter int GAP_COUNT = 1_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   req_digit,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [DIGIT_W-1:0]     digit,
  output logic                   blank,
  output logic                   busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_COUNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_COUNT - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NUM_REQ-1:0] grant_n, done_n, pick;
  logic [DIGIT_W-1:0] digit_n;
  logic blank_n, busy_n, pick_any, pick_upd, arb;
  logic [IW-1:0] last, last_n, pick_idx;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req(req),
    .last(last),
    .gnt(pick),
    .idx(pick_idx),
    .any(pick_any),
    .upd(pick_upd)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      grant <= '0;
      done <= '0;
      digit <= BLANK_CODE;
      blank <= 1'b1;
      busy <= 1'b0;
      last <= IW'(NUM_REQ - 1);
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      grant <= grant_n;
      done <= done_n;
      digit <= digit_n;
      blank <= blank_n;
      busy <= busy_n;
      last <= last_n;
    end
  end
  // Arbitration happens in IDLE and on the final GAP cycle, so a held request
  // goes straight back to SHOW without passing through IDLE.
  always_comb begin
    state_n = state;
    cnt_n = cnt + CNT_W'(1);
    grant_n = grant;
    done_n = '0;
    digit_n = digit;
    blank_n = blank;
    busy_n = busy;
    last_n = last;
    arb = (state == IDLE) || (state == GAP && cnt == GAP_LAST);
    if (state == SHOW && cnt == HOLD_LAST) begin
      state_n = GAP;
      cnt_n = '0;
      grant_n = '0;
      done_n = grant;
      blank_n = 1'b1;
    end
    if (arb) begin
      state_n = pick_any ? SHOW : IDLE;
      cnt_n = '0;
      grant_n = pick;
      digit_n = pick_any ? req_digit[pick_idx*DIGIT_W +: DIGIT_W] : digit;
      blank_n = !pick_any;
      busy_n = pick_any;
      last_n = pick_upd ? pick_idx : last;
    end
  end
endmodule

// File: tb/tb_seg7_display_arbiter.sv
// tb_seg7_display_arbiter: directed self-checking bench with HOLD=4, GAP=2, 4 requesters
module tb_seg7_display_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = '0;
  logic [15:0] req_digit = '0;
  logic [3:0] grant, done, digit;
  logic blank, busy;
  int total = 0;
  int bad = 0;
  seg7_display_arbiter #(.NUM_REQ(4), .HOLD_COUNT(4), .GAP_COUNT(2)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_digit(req_digit),
    .grant(grant),
    .done(done),
    .digit(digit),
    .blank(blank),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [3:0] e;
    step();
    step();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_done", done, 4'b0000);
    chk("rst_digit", digit, 4'd0);
    chk("rst_blank", blank, 1'b1);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    req = 4'b0001;
    req_digit = 16'h0007;
    step();
    for (int c = 0; c < 4; c++) begin
      chk("s1_grant", grant, 4'b0001);
      chk("s1_digit", digit, 4'd7);
      chk("s1_blank", blank, 1'b0);
      step();
    end
    chk("s1_done", done, 4'b0001);
    chk("s1_gap_grant", grant, 4'b0000);
    chk("s1_gap_blank", blank, 1'b1);
    req = 4'b0000;
    step();
    chk("s1_done_clr", done, 4'b0000);
    chk("s1_gap2_busy", busy, 1'b1);
    chk("s1_gap2_blank", blank, 1'b1);
    step();
    chk("s1_idle_busy", busy, 1'b0);
    chk("s1_idle_blank", blank, 1'b1);
    reset = 1'b1;
    req = 4'b1111;
    req_digit = 16'h4321;
    step();
    reset = 1'b0;
    step();
    for (int s = 0; s < 5; s++) begin
      e = 4'(1 << (s % 4));
      for (int c = 0; c < 4; c++) begin
        chk("s2_grant", grant, e);
        chk("s2_digit", digit, 4'((s % 4) + 1));
        chk("s2_blank", blank, 1'b0);
        step();
      end
      chk("s2_done", done, e);
      chk("s2_gap_grant", grant, 4'b0000);
      step();
      chk("s2_gap2_blank", blank, 1'b1);
      chk("s2_gap2_busy", busy, 1'b1);
      step();
    end
    reset = 1'b1;
    req = 4'b0001;
    req_digit = 16'h0005;
    step();
    reset = 1'b0;
    step();
    chk("s3_grant", grant, 4'b0001);
    chk("s3_digit", digit, 4'd5);
    req_digit = 16'h0009;
    req = 4'b0000;
    for (int c = 1; c < 4; c++) begin
      step();
      chk("s3_hold_digit", digit, 4'd5);
      chk("s3_hold_grant", grant, 4'b0001);
    end
    step();
    chk("s3_done", done, 4'b0001);
    step();
    step();
    chk("s3_idle_busy", busy, 1'b0);
    req = 4'b0010;
    req_digit = 16'h00a0;
    step();
    chk("s4_grant", grant, 4'b0010);
    chk("s4_digit", digit, 4'ha);
    step();
    reset = 1'b1;
    req = 4'b1111;
    req_digit = 16'h4321;
    step();
    chk("s4_rst_grant", grant, 4'b0000);
    chk("s4_rst_done", done, 4'b0000);
    chk("s4_rst_blank", blank, 1'b1);
    chk("s4_rst_busy", busy, 1'b0);
    reset = 1'b0;
    step();
    chk("s4_first_grant", grant, 4'b0001);
    chk("s4_first_digit", digit, 4'd1);
    reset = 1'b1;
    req = 4'b0100;
    req_digit = 16'h0860;
    step();
    reset = 1'b0;
    step();
    chk("s5_grant2", grant, 4'b0100);
    chk("s5_digit2", digit, 4'd8);
    req = 4'b0110;
    step();
    step();
    step();
    step();
    chk("s5_done2", done, 4'b0100);
    req = 4'b0010;
    step();
    req = 4'b0110;
    step();
    chk("s5_grant1", grant, 4'b0010);
    chk("s5_digit1", digit, 4'd6);
    step();
    step();
    step();
    step();
    chk("s5_done1", done, 4'b0010);
    step();
    step();
    chk("s5_grant2_again", grant, 4'b0100);
    reset = 1'b1;
    req = 4'b1110;
    req_digit = 16'h3210;
    step();
    reset = 1'b0;
    step();
    chk("s6_grant1", grant, 4'b0010);
    req = 4'b1111;
    step();
    step();
    step();
    step();
    chk("s6_done1", done, 4'b0010);
    step();
    step();
`ifdef SEG7_ARB_PRIO0_EN
    chk("s6_next_grant", grant, 4'b0001);
    chk("s6_next_digit", digit, 4'd0);
`else
    chk("s6_next_grant", grant, 4'b0100);
    chk("s6_next_digit", digit, 4'd2);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
